// File: rtl/da2_pkg.sv
// -----------------------------------------------------------------------------
// da2_pkg
// Shared definitions for the Pmod DA2 serializer: frame geometry, power-down
// field encoding, the serializer state type and the frame builder.
// -----------------------------------------------------------------------------
package da2_pkg;

  localparam int DA2_FRAME_BITS = 16;
  localparam int DA2_SAMPLE_W   = 12;
  localparam logic [1:0] DA2_PD_NORMAL = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } da2_state_t;

  // Build one 16-bit DAC word: {2'b00, PD, sample}. When to_offset is set the
  // sample MSB is flipped, turning two's complement into offset binary.
  function automatic logic [DA2_FRAME_BITS-1:0] da2_build_frame(
    input logic [DA2_SAMPLE_W-1:0] sample,
    input logic                    to_offset
  );
    logic [DA2_SAMPLE_W-1:0] coded;
    coded = sample;
    coded[DA2_SAMPLE_W-1] = sample[DA2_SAMPLE_W-1] ^ to_offset;
    return {2'b00, DA2_PD_NORMAL, coded};
  endfunction

endpackage

// File: rtl/da2_dac_serializer_if.sv
// -----------------------------------------------------------------------------
// da2_dac_serializer_if
// Sample-pair valid/ready handshake between the audio datapath and the DA2
// serializer.
//   sample_valid : upstream has a sample pair (master -> slave)
//   sample_ready : serializer idle, pair accepted this cycle if valid
//   sample_a     : channel A sample, drives SDATA_DA2[0]
//   sample_b     : channel B sample, drives SDATA_DA2[1]
// -----------------------------------------------------------------------------
interface da2_dac_serializer_if #(
  parameter int DATA_W = da2_pkg::DA2_SAMPLE_W
);

  logic              sample_valid;
  logic              sample_ready;
  logic [DATA_W-1:0] sample_a;
  logic [DATA_W-1:0] sample_b;

  modport master (
    output sample_valid,
    output sample_a,
    output sample_b,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  sample_a,
    input  sample_b,
    output sample_ready
  );

endinterface

// File: rtl/da2_clk_div.sv
// -----------------------------------------------------------------------------
// da2_clk_div
// SCLK generator for the DA2 serializer. While enabled, SCLK toggles every
// CLK_DIV clk cycles; rise_tick / fall_tick pulse for one cycle on the clk
// edge that makes SCLK rise / fall. While disabled, SCLK is held high and the
// counter is parked at zero so the first half-period after enable is full.
//   clk, rst  : system clock, asynchronous active-low reset
//   en        : run the divider
//   sclk      : divided serial clock (idles high)
//   rise_tick : this edge drives sclk 0 -> 1
//   fall_tick : this edge drives sclk 1 -> 0
// -----------------------------------------------------------------------------
module da2_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             sclk_reg, sclk_next;
  logic             terminal;

  assign terminal  = en && (cnt_reg == CNT_LAST);
  // Ticks are combinational so the serializer acts on the same edge that
  // moves SCLK.
  assign rise_tick = terminal && !sclk_reg;
  assign fall_tick = terminal && sclk_reg;
  assign sclk      = sclk_reg;

  always_comb begin
    cnt_next  = cnt_reg;
    sclk_next = sclk_reg;
    if (!en) begin
      cnt_next  = '0;
      sclk_next = 1'b1;
    end else if (terminal) begin
      cnt_next  = '0;
      sclk_next = ~sclk_reg;
    end else begin
      cnt_next  = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b1;
    end else begin
      cnt_reg  <= cnt_next;
      sclk_reg <= sclk_next;
    end
  end

endmodule

// File: rtl/da2_dac_serializer.sv
// -----------------------------------------------------------------------------
// da2_dac_serializer
// Accepts one 12-bit A/B sample pair per handshake and shifts it out to the
// Pmod DA2 as two parallel 16-bit frames ({00, PD=00, sample}, MSB first),
// framed by active-low SYNC and clocked by a divided SCLK. Data changes on
// SCLK rising edges; the DAC samples on falling edges. Each frame is followed
// by a 2*CLK_DIV cycle gap with SYNC and SCLK high.
//   clk, rst   : system clock, asynchronous active-low reset
//   smp        : slave side of the sample-pair handshake
//   SCLK_DA2   : DAC serial clock, idles high
//   SYNC_DA2   : frame sync, active-low
//   SDATA_DA2  : [0] channel A, [1] channel B serial data
//   busy       : frame or inter-frame gap in progress
// Parameters: CLK_DIV (>=1) clk cycles per SCLK half-period, DATA_W (must be 12).
// Build option: define DA2_SIGNED_IN_EN to accept two's complement samples
// (MSB inverted at latch); otherwise samples are offset binary, unchanged.
// -----------------------------------------------------------------------------
module da2_dac_serializer #(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  da2_dac_serializer_if.slave        smp,
  output logic                       SCLK_DA2,
  output logic                       SYNC_DA2,
  output logic [1:0]                 SDATA_DA2,
  output logic                       busy
);

  import da2_pkg::*;

  if (DATA_W != DA2_SAMPLE_W) begin : g_bad_width
    $error("da2_dac_serializer: DATA_W must be 12 for the DA2");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("da2_dac_serializer: CLK_DIV must be at least 1");
  end

  localparam int GAP_CYCLES = 2 * CLK_DIV;
  localparam int GAP_W      = $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam int BIT_W      = $clog2(DA2_FRAME_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DA2_FRAME_BITS - 1);

`ifdef DA2_SIGNED_IN_EN
  localparam logic TO_OFFSET = 1'b1;
`else
  localparam logic TO_OFFSET = 1'b0;
`endif

  da2_state_t         state_reg, state_next;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic               last_fall_reg;
  logic               sync_reg, sync_next;
  logic               clk_en, rise_tick, fall_tick, sclk;
  logic               accept, last_bit, gap_done, frame_done;
  logic [DA2_SAMPLE_W-1:0] sample_in [2];

  assign sample_in[0] = smp.sample_a;
  assign sample_in[1] = smp.sample_b;

  da2_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (clk_en),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Decoded directly from the state register so the ready path has no
  // dependency on the next-state logic.
  assign accept     = smp.sample_valid && (state_reg == IDLE);
  assign last_bit   = (bit_cnt_reg == BIT_LAST);
  // The frame ends on the SCLK rise that follows the 16th falling edge,
  // i.e. one half-period after the DAC took the last bit.
  assign frame_done = rise_tick && last_fall_reg;
  assign gap_done   = (gap_cnt_reg == GAP_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = SHIFT;
      SHIFT:   if (frame_done) state_next = GAP;
      GAP:     if (gap_done)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    smp.sample_ready = 1'b0;
    busy             = 1'b1;
    clk_en           = 1'b0;
    case (state_reg)
      IDLE: begin
        smp.sample_ready = 1'b1;
        busy             = 1'b0;
      end
      SHIFT:   clk_en = 1'b1;
      GAP:     clk_en = 1'b0;
      default: begin
        smp.sample_ready = 1'b0;
        busy             = 1'b0;
      end
    endcase
  end

  // SYNC is registered from the next state so it falls on the accept edge
  // and rises on the frame-done edge without decode glitches.
  assign sync_next = (state_next != SHIFT);

  // Bit / gap counters and frame sync
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      last_fall_reg <= 1'b0;
      sync_reg      <= 1'b1;
    end else begin
      sync_reg <= sync_next;
      case (state_reg)
        IDLE: begin
          bit_cnt_reg   <= '0;
          gap_cnt_reg   <= '0;
          last_fall_reg <= 1'b0;
        end
        SHIFT: begin
          // bit_cnt counts bits already advanced past; once at the last bit
          // the next falling edge is the 16th.
          if (fall_tick && last_bit) begin
            last_fall_reg <= 1'b1;
          end
          if (rise_tick && !last_fall_reg) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        GAP:     gap_cnt_reg <= gap_cnt_reg + 1'b1;
        default: gap_cnt_reg <= '0;
      endcase
    end
  end

  // Per-channel shift registers. The MSB is the line value, so clearing the
  // register at frame end forces SDATA to 00 outside SHIFT.
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [DA2_FRAME_BITS-1:0] shift_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shift_reg <= '0;
      end else if (accept) begin
        shift_reg <= da2_build_frame(sample_in[gi], TO_OFFSET);
      end else if ((state_reg == SHIFT) && rise_tick) begin
        if (last_fall_reg) begin
          shift_reg <= '0;
        end else begin
          shift_reg <= {shift_reg[DA2_FRAME_BITS-2:0], 1'b0};
        end
      end
    end

    assign SDATA_DA2[gi] = shift_reg[DA2_FRAME_BITS-1];
  end

  assign SCLK_DA2 = sclk;
  assign SYNC_DA2 = sync_reg;

endmodule

// File: tb/tb_da2_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_da2_dac_serializer
// Directed bench for da2_dac_serializer. Two instances share clk/rst: one with
// CLK_DIV=2 and one with CLK_DIV=1. Bits are recovered the way the DAC sees
// them: on every SCLK 1->0 transition while SYNC is low.
// -----------------------------------------------------------------------------
module tb_da2_dac_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  da2_dac_serializer_if #(.DATA_W(12)) ifc2 ();
  da2_dac_serializer_if #(.DATA_W(12)) ifc1 ();

  logic       sclk2, sync2, busy2;
  logic [1:0] sdata2;
  logic       sclk1, sync1, busy1;
  logic [1:0] sdata1;

  da2_dac_serializer #(.CLK_DIV(2), .DATA_W(12)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .smp       (ifc2),
    .SCLK_DA2  (sclk2),
    .SYNC_DA2  (sync2),
    .SDATA_DA2 (sdata2),
    .busy      (busy2)
  );

  da2_dac_serializer #(.CLK_DIV(1), .DATA_W(12)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .smp       (ifc1),
    .SCLK_DA2  (sclk1),
    .SYNC_DA2  (sync1),
    .SDATA_DA2 (sdata1),
    .busy      (busy1)
  );

  int checks   = 0;
  int failures = 0;
  int sel      = 0;   // 0: CLK_DIV=2 instance, 1: CLK_DIV=1 instance

  function automatic logic o_sclk();
    return (sel != 0) ? sclk1 : sclk2;
  endfunction
  function automatic logic o_sync();
    return (sel != 0) ? sync1 : sync2;
  endfunction
  function automatic logic o_busy();
    return (sel != 0) ? busy1 : busy2;
  endfunction
  function automatic logic o_ready();
    return (sel != 0) ? ifc1.sample_ready : ifc2.sample_ready;
  endfunction
  function automatic logic [1:0] o_sdata();
    return (sel != 0) ? sdata1 : sdata2;
  endfunction

  task automatic drive(input logic v, input logic [11:0] a, input logic [11:0] b);
    if (sel != 0) begin
      ifc1.sample_valid = v; ifc1.sample_a = a; ifc1.sample_b = b;
    end else begin
      ifc2.sample_valid = v; ifc2.sample_a = a; ifc2.sample_b = b;
    end
  endtask

  task automatic drive_valid(input logic v);
    if (sel != 0) ifc1.sample_valid = v;
    else          ifc2.sample_valid = v;
  endtask

  task automatic drive_a(input logic [11:0] a);
    if (sel != 0) ifc1.sample_a = a;
    else          ifc2.sample_a = a;
  endtask

  // Present a pair for exactly one accept edge; returns #1 after that edge.
  task automatic send(input logic [11:0] a, input logic [11:0] b);
    int w;
    w = 0;
    while (!o_ready() && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (o_ready() !== 1'b1) begin
      failures++;
      $display("FAIL send_ready: ready=%b required 1", o_ready());
    end
    drive(1'b1, a, b);
    @(posedge clk); #1;
    drive_valid(1'b0);
  endtask

  // Called #1 after the accept edge. Records bits on SCLK falls, the cycle
  // index of the first/last fall, and ready latency counted from the accept
  // edge to the first edge at which a new pair could be accepted. When
  // poke_fall>0, sample_a is zeroed and valid raised at that fall; valid is
  // dropped as soon as ready returns.
  task automatic capture_frame(input int poke_fall,
                               output logic [15:0] fa, output logic [15:0] fb,
                               output int falls, output int first_fall,
                               output int last_fall, output int ready_lat);
    logic       prev;
    logic [1:0] d;
    fa = '0; fb = '0; falls = 0;
    first_fall = -1; last_fall = -1; ready_lat = -1;
    prev = o_sclk();
    for (int n = 1; n <= 300; n++) begin
      @(posedge clk); #1;
      if (prev && !o_sclk() && !o_sync()) begin
        d  = o_sdata();
        fa = {fa[14:0], d[0]};
        fb = {fb[14:0], d[1]};
        falls++;
        if (first_fall < 0) first_fall = n;
        last_fall = n;
        if (falls == poke_fall) begin
          drive_a(12'h000);
          drive_valid(1'b1);
        end
      end
      prev = o_sclk();
      if (o_ready()) begin
        ready_lat = n + 1;
        drive_valid(1'b0);
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (sync2 !== 1'b1)   begin failures++; $display("FAIL rst_sync: got %b required 1", sync2); end
    checks++; if (sclk2 !== 1'b1)   begin failures++; $display("FAIL rst_sclk: got %b required 1", sclk2); end
    checks++; if (sdata2 !== 2'b00) begin failures++; $display("FAIL rst_sdata: got %b required 00", sdata2); end
    checks++; if (busy2 !== 1'b0)   begin failures++; $display("FAIL rst_busy: got %b required 0", busy2); end
    checks++; if (ifc2.sample_ready !== 1'b1) begin failures++; $display("FAIL rst_ready: got %b required 1", ifc2.sample_ready); end
    checks++; if (sync1 !== 1'b1 || sclk1 !== 1'b1) begin failures++; $display("FAIL rst_div1: sync=%b sclk=%b required 1 1", sync1, sclk1); end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifc2.sample_ready !== 1'b1 || sync2 !== 1'b1 || sdata2 !== 2'b00) begin
      failures++; $display("FAIL idle_after_rst: ready=%b sync=%b sdata=%b required 1 1 00", ifc2.sample_ready, sync2, sdata2);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    logic [15:0] fa, fb;
    int falls, ff, lf, rl;
    sel = 0;
    send(12'hCDE, 12'h3FC);
    checks++; if (sync2 !== 1'b0 || sclk2 !== 1'b1 || sdata2 !== 2'b00) begin
      failures++; $display("FAIL single_start: sync=%b sclk=%b sdata=%b required 0 1 00", sync2, sclk2, sdata2);
    end
    capture_frame(0, fa, fb, falls, ff, lf, rl);
    checks++; if (fa !== 16'h0CDE) begin failures++; $display("FAIL single_a: got %h required 0cde", fa); end
    checks++; if (fb !== 16'h03FC) begin failures++; $display("FAIL single_b: got %h required 03fc", fb); end
    checks++; if (falls !== 16)    begin failures++; $display("FAIL single_falls: got %0d required 16", falls); end
    checks++; if (rl !== 69)       begin failures++; $display("FAIL single_ready: got %0d required 69", rl); end
    checks++; if (ff !== 2)        begin failures++; $display("FAIL single_first_fall: got %0d required 2", ff); end
    checks++; if (lf - ff !== 60)  begin failures++; $display("FAIL single_sclk_period: got %0d required 60", lf - ff); end
    $display("single frame: a=%h b=%h falls=%0d ready=%0d", fa, fb, falls, rl);
  endtask

  task automatic test_back_to_back();
    logic [11:0] av [4];
    logic [11:0] bv [4];
    logic [15:0] fa [4];
    logic [15:0] fb [4];
    int falls [4];
    int gapc [4];
    int acc_cyc [4];
    int acc, cyc;
    logic rdy_prev, prev, holding;
    logic [1:0] d;
    av = '{12'h123, 12'hFED, 12'h0F0, 12'hA5A};
    bv = '{12'h456, 12'h789, 12'hF0F, 12'h5A5};
    for (int i = 0; i < 4; i++) begin
      fa[i] = '0; fb[i] = '0; falls[i] = 0; gapc[i] = 0; acc_cyc[i] = 0;
    end
    sel = 0; acc = 0; cyc = 0;
    drive(1'b1, av[0], bv[0]);
    holding  = 1'b1;
    rdy_prev = o_ready();
    prev     = o_sclk();
    while (cyc < 400) begin
      @(posedge clk); cyc++; #1;
      if (rdy_prev && holding) begin
        acc_cyc[acc] = cyc;
        acc++;
        if (acc < 4) begin
          drive(1'b1, av[acc], bv[acc]);
        end else begin
          drive_valid(1'b0);
          holding = 1'b0;
        end
      end
      if (acc > 0) begin
        if (prev && !o_sclk() && !o_sync()) begin
          d = o_sdata();
          fa[acc-1] = {fa[acc-1][14:0], d[0]};
          fb[acc-1] = {fb[acc-1][14:0], d[1]};
          falls[acc-1]++;
        end
        if (o_sync() && o_busy()) gapc[acc-1]++;
      end
      prev     = o_sclk();
      rdy_prev = o_ready();
      if (acc == 4 && !holding && o_ready()) break;
    end
    drive_valid(1'b0);
    checks++; if (acc !== 4) begin failures++; $display("FAIL b2b_accepts: got %0d required 4", acc); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (fa[i] !== {4'h0, av[i]}) begin failures++; $display("FAIL b2b_a%0d: got %h required %h", i, fa[i], {4'h0, av[i]}); end
      checks++; if (fb[i] !== {4'h0, bv[i]}) begin failures++; $display("FAIL b2b_b%0d: got %h required %h", i, fb[i], {4'h0, bv[i]}); end
      checks++; if (falls[i] !== 16) begin failures++; $display("FAIL b2b_falls%0d: got %0d required 16", i, falls[i]); end
      // Gap = cycles with SYNC high while busy, between frames.
      checks++; if (gapc[i] !== 4) begin failures++; $display("FAIL b2b_gap%0d: got %0d required 4", i, gapc[i]); end
      if (i > 0) begin
        checks++; if (acc_cyc[i] - acc_cyc[i-1] !== 69) begin
          failures++; $display("FAIL b2b_spacing%0d: got %0d required 69", i, acc_cyc[i] - acc_cyc[i-1]);
        end
      end
      $display("b2b frame %0d: a=%h b=%h gap=%0d accept_cycle=%0d", i, fa[i], fb[i], gapc[i], acc_cyc[i]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] fa, fb;
    int falls, ff, lf, rl;
    logic prev;
    sel = 0;
    send(12'h2AA, 12'h3FF);
    prev  = o_sclk();
    falls = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (prev && !o_sclk() && !o_sync()) falls++;
      prev = o_sclk();
      if (falls == 7) break;
    end
    checks++; if (falls !== 7) begin failures++; $display("FAIL rmf_reach7: got %0d required 7", falls); end
    #2 rst = 1'b0;
    #1;
    checks++; if (sync2 !== 1'b1)   begin failures++; $display("FAIL rmf_sync: got %b required 1", sync2); end
    checks++; if (sclk2 !== 1'b1)   begin failures++; $display("FAIL rmf_sclk: got %b required 1", sclk2); end
    checks++; if (sdata2 !== 2'b00) begin failures++; $display("FAIL rmf_sdata: got %b required 00", sdata2); end
    checks++; if (busy2 !== 1'b0 || ifc2.sample_ready !== 1'b1) begin
      failures++; $display("FAIL rmf_idle: busy=%b ready=%b required 0 1", busy2, ifc2.sample_ready);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    send(12'hFFF, 12'h001);
    capture_frame(0, fa, fb, falls, ff, lf, rl);
    checks++; if (fa !== 16'h0FFF) begin failures++; $display("FAIL rmf_new_a: got %h required 0fff", fa); end
    checks++; if (fb !== 16'h0001) begin failures++; $display("FAIL rmf_new_b: got %h required 0001", fb); end
    checks++; if (falls !== 16 || rl !== 69) begin failures++; $display("FAIL rmf_new_frame: falls=%0d ready=%0d required 16 69", falls, rl); end
    $display("reset mid-frame: new a=%h b=%h", fa, fb);
  endtask

  task automatic test_input_stability();
    logic [15:0] fa, fb;
    int falls, ff, lf, rl;
    sel = 0;
    send(12'hABC, 12'h123);
    capture_frame(5, fa, fb, falls, ff, lf, rl);
    checks++; if (fa !== 16'h0ABC) begin failures++; $display("FAIL stab_a: got %h required 0abc", fa); end
    checks++; if (fb !== 16'h0123) begin failures++; $display("FAIL stab_b: got %h required 0123", fb); end
    checks++; if (falls !== 16)    begin failures++; $display("FAIL stab_falls: got %0d required 16", falls); end
    checks++; if (rl !== 69)       begin failures++; $display("FAIL stab_ready: got %0d required 69", rl); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy2 !== 1'b0) begin failures++; $display("FAIL stab_no_accept: busy=%b required 0", busy2); end
    $display("input stability: a=%h b=%h ready=%0d", fa, fb, rl);
  endtask

  task automatic test_signed_input();
    logic [15:0] fa, fb;
    logic [15:0] exp_a, exp_b;
    int falls, ff, lf, rl;
`ifdef DA2_SIGNED_IN_EN
    exp_a = 16'h0000; exp_b = 16'h0FFF;
`else
    exp_a = 16'h0800; exp_b = 16'h07FF;
`endif
    sel = 0;
    send(12'h800, 12'h7FF);
    capture_frame(0, fa, fb, falls, ff, lf, rl);
    checks++; if (fa !== exp_a) begin failures++; $display("FAIL signed_a: got %h required %h", fa, exp_a); end
    checks++; if (fb !== exp_b) begin failures++; $display("FAIL signed_b: got %h required %h", fb, exp_b); end
    $display("sample coding: a=%h b=%h", fa, fb);
  endtask

  task automatic test_clk_div1();
    logic [15:0] fa, fb;
    int falls, ff, lf, rl;
    sel = 1;
    send(12'h555, 12'hAAA);
    capture_frame(0, fa, fb, falls, ff, lf, rl);
    checks++; if (fa !== 16'h0555) begin failures++; $display("FAIL div1_a: got %h required 0555", fa); end
    checks++; if (fb !== 16'h0AAA) begin failures++; $display("FAIL div1_b: got %h required 0aaa", fb); end
    checks++; if (falls !== 16)    begin failures++; $display("FAIL div1_falls: got %0d required 16", falls); end
    checks++; if (rl !== 35)       begin failures++; $display("FAIL div1_ready: got %0d required 35", rl); end
    checks++; if (ff !== 1)        begin failures++; $display("FAIL div1_first_fall: got %0d required 1", ff); end
    checks++; if (lf - ff !== 30)  begin failures++; $display("FAIL div1_sclk_period: got %0d required 30", lf - ff); end
    $display("clk_div1: a=%h b=%h ready=%0d", fa, fb, rl);
    sel = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ifc2.sample_valid = 1'b0; ifc2.sample_a = '0; ifc2.sample_b = '0;
    ifc1.sample_valid = 1'b0; ifc1.sample_a = '0; ifc1.sample_b = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_input_stability();
    test_signed_input();
    test_clk_div1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/da2_dac_serializer.md
# da2_dac_serializer

Output stage between the audio datapath and the Pmod DA2 dual 12-bit DAC. Accepts one pair of 12-bit samples (channel A/B) per valid/ready handshake and serializes them as two parallel 16-bit frames on `SDATA_DA2[1:0]`, with `SYNC_DA2` framing and a divided `SCLK_DA2`. It consumes the samples produced by the microphone SPI capture and processing path and directly drives the DA2 connector pins.

## Interface
- `CLK_DIV`, 2: `clk` cycles per `SCLK_DA2` half-period. Legal range is ≥1, giving 25 MHz SCLK at 100 MHz `clk` by default.
- `DATA_W`, 12: sample width. Fixed by the DA2; any other value is a synthesis-time error.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: asynchronous, active-low reset.
- `sample_valid` input 1: upstream has a sample pair.
- `sample_ready` output 1: block is idle and can accept a sample pair.
- `sample_a` input 12: channel A sample. Drives `SDATA_DA2[0]`.
- `sample_b` input 12: channel B sample. Drives `SDATA_DA2[1]`.
- `SCLK_DA2` output 1: DAC serial clock. Idles high.
- `SYNC_DA2` output 1: frame sync, active-low.
- `SDATA_DA2` output 2: serial data, MSB first, one bit per channel.
- `busy` output 1: a frame or inter-frame gap is in progress.

## Operation
- Frame layout, per channel, transmitted bit 15 first:
  - bits 15:14 = 00 (don't care)
  - bits 13:12 = 00 (PD, normal operation)
  - bits 11:0 = sample
- FSM states: IDLE, SHIFT, GAP.
- IDLE
  - `sample_ready`=1, `busy`=0.
  - On `sample_valid`&&`sample_ready`, latch both 16-bit frames into shift registers and go to SHIFT.
- SHIFT
  - `SYNC_DA2`=0; SCLK toggles every CLK_DIV cycles.
  - Data updates on SCLK rising edges; the DAC samples on falling edges.
  - After the 16th falling edge plus one half-period, go to GAP.
- GAP
  - `SYNC_DA2`=1, `SCLK_DA2`=1 for 2·CLK_DIV cycles, then go to IDLE.
- `sample_valid` while not ready is ignored; inputs are not sampled. Upstream holds the sample pair until ready.
- Inputs are latched only at accept. Changing `sample_a`/`sample_b` mid-frame has no effect on the frame in flight.
- Reset, including mid-frame: abort immediately and go to IDLE. The partial frame is not resumed.
- Reset values: `SYNC_DA2`=1, `SCLK_DA2`=1, `SDATA_DA2`=00, `busy`=0, `sample_ready`=1 (decoded from IDLE).

## Timing
- Accept at edge T0.
- T0+1: `SYNC_DA2` falls, `SDATA_DA2`=bit 15, `SCLK_DA2`=1.
- Falling edge k (k=1..16) at T0+1+(2k−1)·CLK_DIV. Bit 16−k is stable across that edge, for ≥CLK_DIV cycles each side.
- `SYNC_DA2` rises at T0+1+32·CLK_DIV.
- `sample_ready` reasserts at T0+1+34·CLK_DIV, which is 69 cycles for CLK_DIV=2. This is also the minimum accept-to-accept spacing.
- Back-to-back: if `sample_valid` is held high, the next accept occurs on the first IDLE cycle. There is no extra bubble.
- `SDATA_DA2` is 00 outside SHIFT.

## Configuration
- `DA2_SIGNED_IN_EN`
  - Defined: `sample_a`/`sample_b` are two's complement. Bit 11 is inverted at latch to produce DAC offset binary, so 0x800 → 0x000 and 0x000 → 0x800.
  - Undefined: samples are unsigned offset binary and pass through unchanged.

## Structure
- Package `da2_pkg` holds:
  - `DA2_FRAME_BITS`=16
  - `DA2_PD_NORMAL`=2'b00
  - state enum `da2_state_t` {IDLE, SHIFT, GAP}
- One sub-module, `da2_clk_div`:
  - enable-gated CLK_DIV counter
  - emits single-cycle `rise_tick`/`fall_tick`
  - holds SCLK high when disabled
  - resets to SCLK=1, counter=0
- Bit counter (0..15) and the two shift registers live in the top module.

## Test plan
- Single frame: A=0xCDE, B=0x3FC, CLK_DIV=2 (unsigned build).
  - Bits sampled on SCLK falling edges are A=0x0CDE and B=0x03FC.
  - Exactly 16 falling edges occur while SYNC is low.
  - Ready returns 69 cycles after accept.
- Back-to-back: valid held high with 4 sample pairs.
  - Accepts occur exactly 69 cycles apart.
  - SYNC is high for 4 cycles between frames.
  - All 4 frames are bit-exact.
- Reset mid-frame: assert `rst` low after the 7th falling edge.
  - Same cycle: SYNC=1, SCLK=1, SDATA=00.
  - After release, a new pair A=0xFFF is transmitted intact.
- Input stability: change `sample_a` to 0x000 at the 5th falling edge of an A=0xABC frame.
  - Frame still carries 0x0ABC.
  - Valid asserted mid-frame is not accepted.
- `DA2_SIGNED_IN_EN` build: A=0x800, B=0x7FF.
  - Frames carry 0x0000 and 0x0FFF.
- CLK_DIV=1: A=0x555.
  - SCLK period is 2 cycles.
  - Frame is 0x0555.
  - Ready returns 35 cycles after accept.
